uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the team's transmit-only UART.
- Samples an asynchronous serial line and reassembles bytes LSB first.
- Presents each byte through a one-byte holding register with a level-ready / read-acknowledge handshake.
- Flags framing and overrun errors; sits between the host serial pin and the dumper command logic.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM encoding shared by the UART receiver
// and transmitter (frame levels, payload width, receiver states).
`timescale 1ns/1ps
package uart_pkg;

    // Payload bits per frame; this release supports 8 only.
    localparam int UART_DATA_BITS = 8;

    // Line levels that define an 8N1 frame.
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Receiver FSM encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous level.
// Ports: clk, rst (sync, active-high), i_d (async in), o_q (synced out).
`timescale 1ns/1ps
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Reset to the idle level so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-byte holding register.
// Ports: clk, rst (sync, active-high), rx (async serial, idle high),
//   rxData (last byte), dataReady (unread byte held), readAck (consume),
//   frameError (1-cycle pulse on bad stop bit), overrun (sticky until rst),
//   busy (FSM not idle).
// CLKS_PER_BIT must be even and at least 4.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 dataReady,
    input  logic                 readAck,
    output logic                 frameError,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int IW    = $clog2(DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 w_rxs;

    uart_state_t          r_state;
    uart_state_t          w_state_nx;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nx;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic                 w_deliver;
    logic                 w_ferr;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_ready;
    logic                 r_ferr;
    logic                 r_ovr;

    uart_sync2 #(
        .RST_VAL (IDLE_LVL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rxs)
    );

    // State, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
        end
    end

    // Next-state logic. The counter free-runs inside a bit and is
    // cleared at every decision point, so each state times itself.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CW'(1);
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_deliver  = 1'b0;
        w_ferr     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_rxs == START_LVL) begin
                    w_state_nx = S_START;
                end
            end

            // Re-check the line mid start bit to reject glitches.
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nx = '0;
                    if (w_rxs == START_LVL) begin
                        w_idx_nx   = '0;
                        w_state_nx = S_DATA;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end

            // From here on every sample lands mid-bit.
            S_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nx          = '0;
                    w_shift_nx[r_idx] = w_rxs;
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_idx_nx = r_idx + IW'(1);
                    end
                end
            end

            S_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_nx = '0;
                    if (w_rxs == STOP_LVL) begin
                        w_deliver  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr     = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end
            end

            // A held-low line must not re-trigger a start.
            S_BREAK: begin
                w_cnt_nx = '0;
                if (w_rxs == IDLE_LVL) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Holding register. A delivery always wins over a same-cycle
    // readAck; overrun only flags a byte that was never acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            if (w_deliver) begin
                r_data  <= r_shift;
                r_ready <= 1'b1;
                if (r_ready && !readAck) begin
                    r_ovr <= 1'b1;
                end
            end else if (readAck) begin
                r_ready <= 1'b0;
            end
        end
    end

    assign rxData     = r_data;
    assign dataReady  = r_ready;
    assign frameError = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; serial frames are built
// from bytes, expected bytes and delivery cycles are queued on issue.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;
    // Edges from the first edge that sees rx low (counted as 1).
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       readAck;
    logic [7:0] rxData;
    logic       dataReady;
    logic       frameError;
    logic       overrun;
    logic       busy;

    logic ack_auto = 1'b0;
    logic ack_dir  = 1'b0;
    bit   auto_ack = 1'b0;

    assign readAck = ack_auto | ack_dir;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fe_cnt = 0;

    typedef struct {
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic pr_rdy = 1'b0;
    logic [7:0] pr_dat = 8'h00;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rxData     (rxData),
        .dataReady  (dataReady),
        .readAck    (readAck),
        .frameError (frameError),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: a delivery is a rise of dataReady or a new byte while
    // it is still high (overrun, or readAck in the delivery cycle).
    always @(negedge clk) begin
        if (frameError) fe_cnt++;
        if (!rst && dataReady && (!pr_rdy || rxData != pr_dat)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_delivery: got 0x%0h, none expected",
                         rxData);
            end else begin
                mon_e = sb.pop_front();
                chk("rx_data", {24'h0, rxData}, {24'h0, mon_e.d});
                chk("deliver_cycle", cyc, mon_e.at);
                chk("busy_at_delivery", {31'h0, busy}, 32'h0);
            end
        end
        pr_rdy = dataReady;
        pr_dat = rxData;
    end

    // Consumer that acknowledges each byte after a random delay.
    initial forever begin
        @(negedge clk);
        if (auto_ack && dataReady) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            ack_auto = 1'b1;
            @(negedge clk);
            ack_auto = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, test did not finish");
        $fatal(1, "watchdog");
    end

    task automatic hold(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, 8 data bits LSB first and the stop level; leaves
    // rx at the stop level so a low stop bit can be stretched.
    task automatic send(logic [7:0] b, logic stop, bit push);
        if (push) sb.push_back('{d: b, at: cyc + LAT});
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = stop;
        hold(CPB);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_rxData"}, {24'h0, rxData}, 32'h0);
        chk({tag, "_dataReady"}, {31'h0, dataReady}, 32'h0);
        chk({tag, "_frameError"}, {31'h0, frameError}, 32'h0);
        chk({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    int busy_cnt;
    int fe0;
    logic [7:0] rb;
    int gap;

    initial begin
        rst = 1'b1;
        hold(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        hold(CPB);

        // Clean frame.
        auto_ack = 1'b1;
        send(8'hA5, 1'b1, 1'b1);
        rx = 1'b1;
        hold(2 * CPB);
        chk("a5_no_ferr", fe_cnt, 0);

        // Short low glitch is rejected at mid start bit.
        busy_cnt = 0;
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        hold(1);
        chk("glitch_busy_seen", {31'h0, busy_cnt > 0}, 32'h1);
        chk("glitch_busy_le8", {31'h0, busy_cnt <= 8}, 32'h1);
        chk("glitch_busy_end", {31'h0, busy}, 32'h0);
        chk("glitch_no_ferr", fe_cnt, 0);

        // Bad stop bit, then a held break, then a good frame.
        fe0 = fe_cnt;
        send(8'h3C, 1'b0, 1'b0);
        hold(3 * CPB);
        chk("ferr_one_pulse", fe_cnt, fe0 + 1);
        chk("ferr_busy_in_break", {31'h0, busy}, 32'h1);
        chk("ferr_no_ready", {31'h0, dataReady}, 32'h0);
        rx = 1'b1;
        hold(CPB);
        chk("break_exit_idle", {31'h0, busy}, 32'h0);
        send(8'h55, 1'b1, 1'b1);
        rx = 1'b1;
        hold(3 * CPB);

        // Back-to-back bytes without acknowledge.
        auto_ack = 1'b0;
        send(8'h11, 1'b1, 1'b1);
        send(8'h22, 1'b1, 1'b1);
        rx = 1'b1;
        hold(4);
        chk("ovr_flag", {31'h0, overrun}, 32'h1);
        chk("ovr_data", {24'h0, rxData}, 32'h22);
        chk("ovr_ready", {31'h0, dataReady}, 32'h1);
        ack_dir = 1'b1;
        hold(1);
        ack_dir = 1'b0;
        chk("ack_clears_ready", {31'h0, dataReady}, 32'h0);
        hold(CPB);
        chk("ovr_sticky", {31'h0, overrun}, 32'h1);
        ack_dir = 1'b1;
        hold(1);
        ack_dir = 1'b0;
        chk("idle_ack_ignored", {31'h0, dataReady}, 32'h0);

        // Only reset clears overrun.
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        chk("rst_clears_ovr", {31'h0, overrun}, 32'h0);

        // readAck coincides with delivery of the second byte.
        send(8'h33, 1'b1, 1'b1);
        rx = 1'b1;
        hold(CPB);
        fork
            send(8'h44, 1'b1, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                ack_dir = 1'b1;
                @(posedge clk);
                #1;
                ack_dir = 1'b0;
            end
        join
        rx = 1'b1;
        hold(4);
        chk("same_cycle_ready", {31'h0, dataReady}, 32'h1);
        chk("same_cycle_data", {24'h0, rxData}, 32'h44);
        chk("same_cycle_no_ovr", {31'h0, overrun}, 32'h0);

        // Reset in the middle of data bit 3 of 0xF0.
        rx = 1'b0;
        hold(CPB);
        hold(3 * CPB);
        hold(CPB / 2);
        chk("mid_frame_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        rx  = 1'b1;
        hold(1);
        chk_reset_vals("midrst");
        rst = 1'b0;
        hold(12 * CPB);
        chk("midrst_no_delivery", {31'h0, dataReady}, 32'h0);
        auto_ack = 1'b1;
        send(8'h5A, 1'b1, 1'b1);
        rx = 1'b1;
        hold(3 * CPB);

        // Random bytes with random idle gaps, including none.
        for (int k = 0; k < 12; k++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 2);
            send(rb, 1'b1, 1'b1);
            rx = 1'b1;
            if (gap > 0) hold(gap * CPB);
        end
        hold(3 * CPB);

        chk("scoreboard_empty", sb.size(), 0);
        chk("total_ferr", fe_cnt, 1);
        chk("final_no_ovr", {31'h0, overrun}, 32'h0);
        chk("final_idle", {31'h0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
